// File: rtl/stream_reader_pkg.sv
// stream_reader_pkg: shared sizes, FSM states and AXI read-address constants
package stream_reader_pkg;
  localparam int NUM_LINES = 64;
  localparam int LINE_W = 512;
  localparam int WORD_W = 64;
  localparam int ID_W = 16;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 26 - IDX_W;
  localparam logic [2:0] SIZE_64B = 3'b110;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_0011 = 4'b0011;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_STREAM} state_e;
endpackage

// File: rtl/stream_reader_if.sv
// stream_reader_if: request, word-stream and line-fill buses; slave is the reader, master drives it
interface stream_reader_if;
  import stream_reader_pkg::*;
  logic [31:0] req_addr;
  logic [8:0] req_burst_count;
  logic req_val;
  logic req_rdy;
  logic [ID_W-1:0] s_axi_rid;
  logic [WORD_W-1:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;
  logic s_axi_rlast;
  logic s_axi_rvalid;
  logic s_axi_rready;
  logic [ID_W-1:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic [1:0] m_axi_arlock;
  logic [3:0] m_axi_arcache;
  logic [2:0] m_axi_arprot;
  logic [3:0] m_axi_arqos;
  logic [3:0] m_axi_arregion;
  logic m_axi_arvalid;
  logic m_axi_arready;
  logic [ID_W-1:0] m_axi_rid;
  logic [LINE_W-1:0] m_axi_rdata;
  logic [1:0] m_axi_rresp;
  logic m_axi_rlast;
  logic m_axi_rvalid;
  logic m_axi_rready;
  modport slave (
    input req_addr, req_burst_count, req_val, s_axi_rready, m_axi_arready,
          m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output req_rdy, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
           m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_arvalid, m_axi_rready
  );
  modport master (
    output req_addr, req_burst_count, req_val, s_axi_rready, m_axi_arready,
           m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input req_rdy, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
          m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
          m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/stream_reader_line_ram.sv
// stream_reader_line_ram: direct-mapped line store with tags and valid bits
module stream_reader_line_ram
  import stream_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] rd_line_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic              rd_valid_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);
  logic [LINE_W-1:0] data_q [NUM_LINES];
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else if (we_i) valid_q[wr_idx_i] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[wr_idx_i] <= wr_line_i;
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end
  assign rd_line_o = data_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
endmodule

// File: rtl/stream_reader.sv
// stream_reader: streams consecutive 64-bit words from a line cache, filling misses over AXI
module stream_reader
  import stream_reader_pkg::*;
(
  input logic           clk,
  input logic           reset,
  stream_reader_if.slave bus
);
  state_e state_q;
  logic [28:0] addr_q;
  logic [8:0] cnt_q;
  logic req_rdy_q, rvalid_q, rlast_q, arvalid_q, rready_q;
  logic [LINE_W-1:0] line;
  logic [TAG_W-1:0] line_tag;
  logic line_valid, hit, fill, s_fire;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0] w;
  logic unused_bits;
  // addr_q holds byte address bits [31:3]: word, index and tag slice straight out of it
  assign w = addr_q[2:0];
  assign idx = addr_q[IDX_W+2:3];
  assign tag = addr_q[28:IDX_W+3];
  assign hit = line_valid && line_tag == tag;
  assign fill = state_q == S_R && bus.m_axi_rvalid;
  assign s_fire = rvalid_q && bus.s_axi_rready;
  stream_reader_line_ram u_ram (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (idx),
    .rd_line_o  (line),
    .rd_tag_o   (line_tag),
    .rd_valid_o (line_valid),
    .we_i       (fill),
    .wr_idx_i   (idx),
    .wr_tag_i   (tag),
    .wr_line_i  (bus.m_axi_rdata)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      addr_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_rdy_q <= 1'b1;
          if (req_rdy_q && bus.req_val) begin
            addr_q <= bus.req_addr[31:3];
            cnt_q <= bus.req_burst_count;
            if (bus.req_burst_count != 9'd0) begin
              req_rdy_q <= 1'b0;
              state_q <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            state_q <= S_STREAM;
            rvalid_q <= 1'b1;
            rlast_q <= cnt_q == 9'd1;
          end else begin
            state_q <= S_AR;
            arvalid_q <= 1'b1;
          end
        end
        S_AR: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q <= 1'b1;
            state_q <= S_R;
          end
        end
        S_R: begin
          if (bus.m_axi_rvalid) begin
            rready_q <= 1'b0;
            rvalid_q <= 1'b1;
            rlast_q <= cnt_q == 9'd1;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (s_fire) begin
            cnt_q <= cnt_q - 9'd1;
            addr_q <= addr_q + 29'd1;
            rlast_q <= cnt_q == 9'd2;
            if (cnt_q == 9'd1) begin
              rvalid_q <= 1'b0;
              rlast_q <= 1'b0;
              req_rdy_q <= 1'b1;
              state_q <= S_IDLE;
            end else if (w == 3'd7) begin
              rvalid_q <= 1'b0;
              rlast_q <= 1'b0;
              state_q <= S_LOOKUP;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.req_rdy = req_rdy_q;
  assign bus.s_axi_rid = '0;
  assign bus.s_axi_rdata = line[{w, 6'b0} +: WORD_W];
  assign bus.s_axi_rresp = 2'b00;
  assign bus.s_axi_rlast = rlast_q;
  assign bus.s_axi_rvalid = rvalid_q;
  assign bus.m_axi_arid = '0;
  assign bus.m_axi_araddr = {32'b0, addr_q[28:3], 6'b0};
  assign bus.m_axi_arlen = 8'd0;
  assign bus.m_axi_arsize = SIZE_64B;
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arlock = 2'b00;
  assign bus.m_axi_arcache = CACHE_0011;
  assign bus.m_axi_arprot = 3'b000;
  assign bus.m_axi_arqos = 4'b0000;
  assign bus.m_axi_arregion = 4'b0000;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready = rready_q;
  assign unused_bits = ^{bus.req_addr[2:0], bus.m_axi_rid, bus.m_axi_rresp, bus.m_axi_rlast};
endmodule

// File: tb/tb_stream_reader.sv
// tb_stream_reader: scoreboard bench with a DRAM model whose lanes all equal araddr & 0xFFFFF000
module tb_stream_reader;
  import stream_reader_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  stream_reader_if bus ();
  stream_reader dut (.clk(clk), .reset(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] exp_word_q [$];
  logic exp_last_q [$];
  logic [63:0] exp_ar_q [$];
  bit rr_rand = 0, rr_low = 0;
  bit ar_fire = 0, r_fire = 0, prev_stall = 0;
  logic [63:0] prev_data;
  logic [31:0] mem_a;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    bus.s_axi_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.s_axi_rready = rr_low ? 1'b0 : rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("hold_valid", bus.s_axi_rvalid, 1);
          check("hold_data", bus.s_axi_rdata, prev_data);
        end
        prev_stall = bus.s_axi_rvalid && !bus.s_axi_rready;
        prev_data = bus.s_axi_rdata;
        if (bus.s_axi_rvalid && bus.s_axi_rready) begin
          if (exp_word_q.size() == 0) check("unexpected_word", 1, 0);
          else begin
            check("word", bus.s_axi_rdata, exp_word_q.pop_front());
            check("rlast", bus.s_axi_rlast, exp_last_q.pop_front());
            check("rid_rresp", {bus.s_axi_rid, bus.s_axi_rresp}, 0);
          end
        end
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          if (exp_ar_q.size() == 0) check("unexpected_ar", 1, 0);
          else check("araddr", bus.m_axi_araddr, exp_ar_q.pop_front());
          check("ar_attr", {bus.m_axi_arid, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst,
                bus.m_axi_arlock, bus.m_axi_arcache, bus.m_axi_arprot, bus.m_axi_arqos,
                bus.m_axi_arregion},
                {16'd0, 8'd0, 3'b110, 2'b01, 2'b00, 4'b0011, 3'b000, 4'd0, 4'd0});
          mem_a = bus.m_axi_araddr[31:0];
          ar_fire = 1;
        end
        if (bus.m_axi_rvalid && bus.m_axi_rready) r_fire = 1;
      end
    end
  end

  initial begin
    int st = 0;
    int dly = 0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata = '0;
    bus.m_axi_rid = '0;
    bus.m_axi_rresp = 2'b00;
    bus.m_axi_rlast = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        st = 0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        ar_fire = 0;
        r_fire = 0;
      end else if (st == 0) begin
        if (ar_fire) begin
          ar_fire = 0;
          bus.m_axi_arready = 1'b0;
          dly = $urandom_range(0, 2);
          st = 1;
        end else bus.m_axi_arready = 1'($urandom_range(0, 1));
      end else if (st == 1) begin
        if (dly > 0) dly--;
        else begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata = {8{32'b0, mem_a & 32'hFFFF_F000}};
          st = 2;
        end
      end else if (r_fire) begin
        r_fire = 0;
        bus.m_axi_rvalid = 1'b0;
        st = 0;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input int n, input bit lat_chk = 0);
    int t = 0;
    logic [31:0] wa;
    while (!bus.req_rdy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("req_rdy", bus.req_rdy, 1);
    for (int i = 0; i < n; i++) begin
      wa = (a & ~32'h7) + 32'(8 * i);
      exp_word_q.push_back({32'b0, wa & 32'hFFFF_F000});
      exp_last_q.push_back(i == n - 1);
    end
    bus.req_addr = a;
    bus.req_burst_count = 9'(n);
    bus.req_val = 1'b1;
    @(posedge clk); #1;
    bus.req_val = 1'b0;
    bus.req_addr = $urandom();
    check(n != 0 ? "busy_rdy" : "zero_rdy", bus.req_rdy, n == 0);
    if (lat_chk) begin
      check("hit_early", bus.s_axi_rvalid, 0);
      @(posedge clk); #1;
      check("hit_latency", bus.s_axi_rvalid, 1);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_word_q.size() != 0 || !bus.req_rdy) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("done", exp_word_q.size() == 0 && bus.req_rdy, 1);
    check("ar_left", exp_ar_q.size(), 0);
  endtask

  task automatic check_quiet(input string tag, input logic rdy);
    check({tag, "_req_rdy"}, bus.req_rdy, rdy);
    check({tag, "_rvalid"}, {bus.s_axi_rvalid, bus.s_axi_rlast}, 0);
    check({tag, "_arvalid"}, bus.m_axi_arvalid, 0);
    check({tag, "_rready"}, bus.m_axi_rready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.req_val = 1'b0;
    bus.req_addr = '0;
    bus.req_burst_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset", 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_reset", bus.req_rdy, 1);
    exp_ar_q.push_back(64'h0);
    do_req(32'h0, 1); wait_done();
    do_req(32'h0, 4, 1); wait_done();
    exp_ar_q.push_back(64'h40);
    do_req(32'h0, 9); wait_done();
    exp_ar_q.push_back(64'h800); exp_ar_q.push_back(64'h840); exp_ar_q.push_back(64'h880);
    do_req(32'h830, 17); wait_done();
    exp_ar_q.push_back(64'h1000);
    do_req(32'h1000, 1); wait_done();
    exp_ar_q.push_back(64'h1FC0);
    do_req(32'h1FF8, 1); wait_done();
    exp_ar_q.push_back(64'h0F00_3FC0);
    do_req(32'h0F00_3FF8, 1); wait_done();
    exp_ar_q.push_back(64'h0F00_3000); exp_ar_q.push_back(64'h0F00_3040);
    exp_ar_q.push_back(64'h0F00_3080);
    do_req(32'h0F00_3030, 15); wait_done();
    exp_ar_q.push_back(64'h0);
    do_req(32'h8, 1); wait_done();
    do_req(32'h8, 3, 1); wait_done();
    // stall the stream with rready low, then release into random backpressure
    exp_ar_q.push_back(64'h100); exp_ar_q.push_back(64'h140); exp_ar_q.push_back(64'h180);
    rr_low = 1;
    do_req(32'h100, 20);
    t = 0;
    while (!bus.s_axi_rvalid && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("stall_rvalid", bus.s_axi_rvalid, 1);
    repeat (5) @(posedge clk);
    #1;
    rr_low = 0;
    rr_rand = 1;
    wait_done();
    for (int i = 0; i < 32; i++) exp_ar_q.push_back(64'h2000 + 64'(64 * i));
    do_req(32'h2000, 256); wait_done();
    rr_rand = 0;
    exp_ar_q.push_back(64'hFFFF_FFC0); exp_ar_q.push_back(64'h0);
    do_req(32'hFFFF_FFF0, 4); wait_done();
    do_req(32'h40, 0);
    repeat (10) @(posedge clk);
    #1;
    check_quiet("zero_count", 1'b1);
    wait_done();
    exp_ar_q.push_back(64'h5000);
    do_req(32'h5000, 4);
    t = 0;
    while (!bus.m_axi_rready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("fill_wait", bus.m_axi_rready, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_quiet("mid_reset", 1'b0);
    exp_word_q.delete();
    exp_last_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_quiet("after_reset", 1'b1);
    exp_ar_q.push_back(64'h0);
    do_req(32'h8, 1); wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
